param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits.
REQ-002 SHALL have parameter MIN_VAL, default 0: lower count limit.
REQ-003 SHALL have parameter MAX_VAL, default 2**WIDTH-1: upper count limit.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port areset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port mode  input  2  counting mode: 0 up-wrap, 1 down-wrap, 2 bounce, 3 hold.
REQ-008 SHALL have port load  input  1  synchronous load strobe (present only with UDC_LOAD_EN).
REQ-009 SHALL have port load_val  input  WIDTH  value to load (present only with UDC_LOAD_EN).
REQ-010 SHALL have port data  output  WIDTH  registered count value.
REQ-011 SHALL have port dir  output  1  registered direction, 1 = up.
REQ-012 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.

Function
REQ-013 SHALL, with en=1 in up-wrap mode, step data +1 per cycle, go from MAX_VAL to MIN_VAL, and force dir=1.
REQ-014 SHALL, with en=1 in down-wrap mode, step data -1 per cycle, go from MIN_VAL to MAX_VAL, and force dir=0.
REQ-015 SHALL, with en=1 in bounce mode, step data in the direction of dir; at MAX_VAL with dir=1, the next edge gives data=MAX_VAL-1 and dir=0; at MIN_VAL with dir=0, the next edge gives data=MIN_VAL+1 and dir=1.
REQ-016 SHALL, in hold mode or with en=0, keep data and dir unchanged.
REQ-017 SHALL keep dir unchanged when switching into bounce mode, so bounce resumes in the last direction.
REQ-018 SHALL register tc=1 for exactly the cycle in which an enabled count step has just made data equal MAX_VAL while counting up or MIN_VAL while counting down; tc=0 otherwise, including on load and hold.
REQ-019 SHALL compute all arithmetic modulo 2**WIDTH, with data always within [MIN_VAL, MAX_VAL] after any edge.
REQ-020 SHALL, if data lies outside [MIN_VAL, MAX_VAL] before an enabled step, put data at MIN_VAL on the next edge.
REQ-021 SHALL flag an elaboration error unless MIN_VAL < MAX_VAL <= 2**WIDTH-1.

Reset
REQ-022 SHALL, while areset=0, immediately force data=MIN_VAL, dir=1 and tc=0, independent of clock.
REQ-023 SHALL, on release of areset, count from MIN_VAL upward on the first rising edge with en=1; reset mid-count drops any pending step.

Configuration
REQ-024 SHALL compile load/load_val in when macro UDC_LOAD_EN is defined: load=1 sets data to load_val clamped to [MIN_VAL, MAX_VAL], leaves dir unchanged, and takes priority over en and mode.
REQ-025 SHALL, without UDC_LOAD_EN, omit the load and load_val ports and all load logic; the remaining behaviour is identical.

Structure
REQ-026 SHALL define the mode enum udc_mode_e (UDC_UP, UDC_DOWN, UDC_BOUNCE, UDC_HOLD) in shared package udc_pkg.
REQ-027 SHALL place next-value/next-direction/tc-condition logic in combinational sub-module udc_next_calc; the top holds only registers and load muxing.

Verification (WIDTH=8, defaults, 10 ns clock)
REQ-028 SHALL cover: areset low 10 ns then high, mode=2, en=1 -> data 0,1..255,254..0,1; dir falls on the edge after 255 and rises on the edge after 0; tc high with data=255 and with data=0.
REQ-029 SHALL cover: mode=0 from data=254 -> 255 (tc=1), then 0 (tc=0); mode=1 from data=1 -> 0 (tc=1), then 255.
REQ-030 SHALL cover: en=0 for 5 cycles at data=100, then mode=3 for 5 cycles -> data stays 100, tc=0.
REQ-031 SHALL cover: with MIN_VAL=10 and MAX_VAL=20, UDC_LOAD_EN defined, load_val=30 -> data=20; load_val=5 -> data=10; load and en both high -> load wins.
REQ-032 SHALL cover: areset pulsed low mid-bounce at data=77, dir=0 -> data=0, dir=1 and tc=0 without a clock edge.

Source files
------------

// File: rtl/udc_pkg.sv
`default_nettype none
// =============================================================================
// Package     : udc_pkg
// Description : Shared types for the parameterised up/down counter. Holds the
//               counting-mode encoding used by the counter top and its
//               next-state calculator.
// Contents    : udc_mode_e   - counting mode (up-wrap, down-wrap, bounce, hold)
//               c_udc_mode_w - bit width of the mode field
// Revision    : 1.0 - initial release
// =============================================================================
package udc_pkg;

    localparam int c_udc_mode_w = 2;

    typedef enum logic [c_udc_mode_w-1:0] {
        UDC_UP     = 2'd0,
        UDC_DOWN   = 2'd1,
        UDC_BOUNCE = 2'd2,
        UDC_HOLD   = 2'd3
    } udc_mode_e;

endpackage
`default_nettype wire

// File: rtl/udc_next_calc.sv
`default_nettype none
// =============================================================================
// Module      : udc_next_calc
// Description : Purely combinational next-state logic for the up/down counter.
//               Given the current count, direction, enable and mode it returns
//               the next count, next direction and the terminal-count flag to
//               be registered on the coming edge.
// Ports       : data      in  WIDTH  current registered count
//               dir       in  1      current registered direction (1 = up)
//               en        in  1      count enable
//               mode      in  2      counting mode (udc_mode_e encoding)
//               next_data out WIDTH  count after this edge
//               next_dir  out 1      direction after this edge
//               next_tc   out 1      terminal-count flag after this edge
// Revision    : 1.0 - initial release
// =============================================================================
module udc_next_calc
    import udc_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MIN_VAL = '0,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic [WIDTH-1:0]        data,
    input  logic                    dir,
    input  logic                    en,
    input  logic [c_udc_mode_w-1:0] mode,
    output logic [WIDTH-1:0]        next_data,
    output logic                    next_dir,
    output logic                    next_tc
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    udc_mode_e        w_mode;
    logic             w_step;
    logic             w_lo_ok;
    logic             w_hi_ok;
    logic             w_in_range;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    assign w_mode     = udc_mode_e'(mode);
    assign w_step     = en && (w_mode != UDC_HOLD);
    assign w_inc      = data + c_one;
    assign w_dec      = data - c_one;
    assign w_in_range = w_lo_ok && w_hi_ok;

    // A limit sitting at the edge of the WIDTH-bit range can never be
    // exceeded, so its comparison is dropped rather than left as a
    // constant-true compare.
    if (MIN_VAL == '0) begin : g_lo_open
        assign w_lo_ok = 1'b1;
    end else begin : g_lo_chk
        assign w_lo_ok = (data >= MIN_VAL);
    end

    if (MAX_VAL == '1) begin : g_hi_open
        assign w_hi_ok = 1'b1;
    end else begin : g_hi_chk
        assign w_hi_ok = (data <= MAX_VAL);
    end

    always_comb begin
        next_data = data;
        next_dir  = dir;
        next_tc   = 1'b0;
        if (w_step) begin
            case (w_mode)
                UDC_UP: begin
                    next_dir  = 1'b1;
                    next_data = (data == MAX_VAL) ? MIN_VAL : w_inc;
                end
                UDC_DOWN: begin
                    next_dir  = 1'b0;
                    next_data = (data == MIN_VAL) ? MAX_VAL : w_dec;
                end
                UDC_BOUNCE: begin
                    // Turn around at a limit; the step after the turn
                    // already moves away from that limit.
                    if (dir) begin
                        if (data == MAX_VAL) begin
                            next_dir  = 1'b0;
                            next_data = w_dec;
                        end else begin
                            next_data = w_inc;
                        end
                    end else begin
                        if (data == MIN_VAL) begin
                            next_dir  = 1'b1;
                            next_data = w_inc;
                        end else begin
                            next_data = w_dec;
                        end
                    end
                end
                UDC_HOLD: begin
                end
            endcase

            if (!w_in_range) begin
                // Recovery from an illegal count is not a counting step,
                // so it never raises tc.
                next_data = MIN_VAL;
                next_tc   = 1'b0;
            end else begin
                // next_dir is the direction of the step just taken.
                next_tc = next_dir ? (next_data == MAX_VAL) : (next_data == MIN_VAL);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// =============================================================================
// Module      : param_updown_counter
// Description : Parameterised up/down counter with up-wrap, down-wrap, bounce
//               and hold modes, registered direction and a one-cycle
//               terminal-count pulse. Count limits are MIN_VAL..MAX_VAL.
// Ports       : clock    in  1      rising-edge clock
//               areset   in  1      asynchronous active-low reset
//               en       in  1      count enable
//               mode     in  2      0 up-wrap, 1 down-wrap, 2 bounce, 3 hold
//               load     in  1      synchronous load strobe   (UDC_LOAD_EN)
//               load_val in  WIDTH  value to load, clamped    (UDC_LOAD_EN)
//               data     out WIDTH  registered count
//               dir      out 1      registered direction, 1 = up
//               tc       out 1      registered terminal-count pulse
// Config      : define UDC_LOAD_EN to add the load/load_val ports and the
//               load path; without it the ports and logic are absent.
// Revision    : 1.0 - initial release
// =============================================================================
module param_updown_counter
    import udc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic                    clock,
    input  logic                    areset,
    input  logic                    en,
    input  logic [c_udc_mode_w-1:0] mode,
`ifdef UDC_LOAD_EN
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_val,
`endif
    output logic [WIDTH-1:0]        data,
    output logic                    dir,
    output logic                    tc
);

    if ((WIDTH < 1) || (WIDTH > 31) || (MIN_VAL < 0) || (MIN_VAL >= MAX_VAL) ||
        (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_params
        $error("param_updown_counter: need MIN_VAL < MAX_VAL <= 2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] c_min_val = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_max_val = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic             r_tc;

    logic [WIDTH-1:0] w_next_data;
    logic             w_next_dir;
    logic             w_next_tc;

    udc_next_calc #(
        .WIDTH   (WIDTH),
        .MIN_VAL (c_min_val),
        .MAX_VAL (c_max_val)
    ) u_next_calc (
        .data      (r_data),
        .dir       (r_dir),
        .en        (en),
        .mode      (mode),
        .next_data (w_next_data),
        .next_dir  (w_next_dir),
        .next_tc   (w_next_tc)
    );

`ifdef UDC_LOAD_EN
    logic             w_load_below;
    logic             w_load_above;
    logic [WIDTH-1:0] w_load_clamped;

    if (MIN_VAL == 0) begin : g_load_lo_open
        assign w_load_below = 1'b0;
    end else begin : g_load_lo_chk
        assign w_load_below = (load_val < c_min_val);
    end

    if (c_max_val == '1) begin : g_load_hi_open
        assign w_load_above = 1'b0;
    end else begin : g_load_hi_chk
        assign w_load_above = (load_val > c_max_val);
    end

    assign w_load_clamped = w_load_below ? c_min_val :
                            w_load_above ? c_max_val : load_val;
`endif

    always_ff @(posedge clock or negedge areset) begin
        if (!areset) begin
            r_data <= c_min_val;
            r_dir  <= 1'b1;
            r_tc   <= 1'b0;
        end else begin
`ifdef UDC_LOAD_EN
            // Load overrides en and mode and leaves the direction alone.
            if (load) begin
                r_data <= w_load_clamped;
                r_tc   <= 1'b0;
            end else begin
                r_data <= w_next_data;
                r_dir  <= w_next_dir;
                r_tc   <= w_next_tc;
            end
`else
            r_data <= w_next_data;
            r_dir  <= w_next_dir;
            r_tc   <= w_next_tc;
`endif
        end
    end

    assign data = r_data;
    assign dir  = r_dir;
    assign tc   = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// =============================================================================
// Module      : tb_param_updown_counter
// Description : Self-checking bench for param_updown_counter. Two instances:
//               u_dut_a with default limits (0..255) and u_dut_b with limits
//               10..20. Both are compared every cycle against a behavioural
//               model; directed tables and sequences cover the corner cases.
//               With UDC_LOAD_EN defined the load path is exercised too.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_param_updown_counter;

    logic       clock;
    logic       areset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] data_a, data_b;
    logic       dir_a, dir_b, tc_a, tc_b;
    logic       ld_a, ld_b;
    logic [7:0] ldv_a, ldv_b;

    int total = 0;
    int bad   = 0;

    typedef struct { int v; int d; int tc; } mst_t;
    mst_t ma, mb;

    typedef struct { bit en; int mode; int d; int dr; int tc; } vec_t;
    vec_t tbl[15];

    param_updown_counter #(.WIDTH(8)) u_dut_a (
        .clock    (clock),
        .areset   (areset),
        .en       (en),
        .mode     (mode),
`ifdef UDC_LOAD_EN
        .load     (ld_a),
        .load_val (ldv_a),
`endif
        .data     (data_a),
        .dir      (dir_a),
        .tc       (tc_a)
    );

    param_updown_counter #(.WIDTH(8), .MIN_VAL(10), .MAX_VAL(20)) u_dut_b (
        .clock    (clock),
        .areset   (areset),
        .en       (en),
        .mode     (mode),
`ifdef UDC_LOAD_EN
        .load     (ld_b),
        .load_val (ldv_b),
`endif
        .data     (data_b),
        .dir      (dir_b),
        .tc       (tc_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: the count lives on a ring of (mx-mn+1) values.
    function automatic mst_t mstep(mst_t s, bit e, int m, bit ld, int ldv, int mn, int mx);
        mst_t r;
        int   span;
        span = mx - mn + 1;
        r    = s;
        r.tc = 0;
        if (ld) begin
            r.v = (ldv < mn) ? mn : (ldv > mx) ? mx : ldv;
            return r;
        end
        if (!e || m == 3) return r;
        case (m)
            0: begin r.d = 1; r.v = mn + (s.v - mn + 1) % span; end
            1: begin r.d = 0; r.v = mn + (s.v - mn - 1 + span) % span; end
            default: begin
                if (s.d == 1 && s.v == mx) r.d = 0;
                else if (s.d == 0 && s.v == mn) r.d = 1;
                r.v = s.v + ((r.d == 1) ? 1 : -1);
            end
        endcase
        r.tc = (r.d == 1) ? int'(r.v == mx) : int'(r.v == mn);
        return r;
    endfunction

    task automatic compare_models();
        chk("a_data", int'(data_a), ma.v);
        chk("a_dir",  int'(dir_a),  ma.d);
        chk("a_tc",   int'(tc_a),   ma.tc);
        chk("b_data", int'(data_b), mb.v);
        chk("b_dir",  int'(dir_b),  mb.d);
        chk("b_tc",   int'(tc_b),   mb.tc);
    endtask

    // Called #1 after a rising edge; ends #1 after the next one.
    task automatic cycle(input bit e, input int m);
        en   = e;
        mode = 2'(m);
        ma   = mstep(ma, e, m, ld_a, int'(ldv_a), 0, 255);
        mb   = mstep(mb, e, m, ld_b, int'(ldv_b), 10, 20);
        @(posedge clock);
        #1;
        compare_models();
    endtask

    task automatic model_reset();
        ma.v = 0;  ma.d = 1; ma.tc = 0;
        mb.v = 10; mb.d = 1; mb.tc = 0;
    endtask

    // Asserts reset between edges and checks it acts without a clock edge.
    task automatic do_reset();
        #2 areset = 1'b0;
        #1;
        chk("rst_a_data", int'(data_a), 0);
        chk("rst_a_dir",  int'(dir_a),  1);
        chk("rst_a_tc",   int'(tc_a),   0);
        chk("rst_b_data", int'(data_b), 10);
        @(posedge clock);
        #1;
        chk("rst_held_a_data", int'(data_a), 0);
        chk("rst_held_b_dir",  int'(dir_b),  1);
        #1 areset = 1'b1;
        model_reset();
    endtask

    initial begin
        areset = 1'b0;
        en     = 1'b0;
        mode   = 2'd0;
        ld_a   = 1'b0;
        ld_b   = 1'b0;
        ldv_a  = 8'd0;
        ldv_b  = 8'd0;
        model_reset();

        tbl[0]  = '{1, 1, 255, 0, 0};
        tbl[1]  = '{1, 1, 254, 0, 0};
        tbl[2]  = '{1, 0, 255, 1, 1};
        tbl[3]  = '{1, 0,   0, 1, 0};
        tbl[4]  = '{1, 0,   1, 1, 0};
        tbl[5]  = '{1, 1,   0, 0, 1};
        tbl[6]  = '{1, 1, 255, 0, 0};
        tbl[7]  = '{0, 0, 255, 0, 0};
        tbl[8]  = '{1, 3, 255, 0, 0};
        tbl[9]  = '{1, 2, 254, 0, 0};
        tbl[10] = '{1, 0, 255, 1, 1};
        tbl[11] = '{1, 2, 254, 0, 0};
        tbl[12] = '{1, 2, 253, 0, 0};
        tbl[13] = '{1, 0, 254, 1, 0};
        tbl[14] = '{1, 2, 255, 1, 1};

        // Power-on reset, 10 ns low.
        #9;
        chk("por_a_data", int'(data_a), 0);
        chk("por_a_dir",  int'(dir_a),  1);
        chk("por_a_tc",   int'(tc_a),   0);
        chk("por_b_data", int'(data_b), 10);
        #1 areset = 1'b1;

        // Full bounce sweep: 1..255, 254..0, 1.
        for (int i = 0; i < 511; i++) begin
            cycle(1'b1, 2);
            if (i == 254) begin
                chk("bnc_top_data", int'(data_a), 255);
                chk("bnc_top_tc",   int'(tc_a),   1);
                chk("bnc_top_dir",  int'(dir_a),  1);
            end
            if (i == 255) begin
                chk("bnc_turn_data", int'(data_a), 254);
                chk("bnc_turn_dir",  int'(dir_a),  0);
                chk("bnc_turn_tc",   int'(tc_a),   0);
            end
            if (i == 509) begin
                chk("bnc_bot_data", int'(data_a), 0);
                chk("bnc_bot_tc",   int'(tc_a),   1);
            end
            if (i == 510) begin
                chk("bnc_end_data", int'(data_a), 1);
                chk("bnc_end_dir",  int'(dir_a),  1);
            end
        end

        // Directed table: wrap limits, hold, bounce resume direction.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].en, tbl[i].mode);
            chk($sformatf("tbl%0d_data", i), int'(data_a), tbl[i].d);
            chk($sformatf("tbl%0d_dir",  i), int'(dir_a),  tbl[i].dr);
            chk($sformatf("tbl%0d_tc",   i), int'(tc_a),   tbl[i].tc);
        end

        // Count to 100, then en=0 and hold mode keep it there.
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1'b1, 0);
        chk("at100", int'(data_a), 100);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 0);
            chk("en0_data", int'(data_a), 100);
            chk("en0_tc",   int'(tc_a),   0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 3);
            chk("hold_data", int'(data_a), 100);
            chk("hold_tc",   int'(tc_a),   0);
        end

        // Reset mid-bounce at 77 going down; first step afterwards counts up.
        do_reset();
        for (int i = 0; i < 179; i++) cycle(1'b1, 1);
        chk("at77_data", int'(data_a), 77);
        chk("at77_dir",  int'(dir_a),  0);
        mode = 2'd2;
        do_reset();
        cycle(1'b1, 2);
        chk("post_rst_data", int'(data_a), 1);
        chk("post_rst_dir",  int'(dir_a),  1);

`ifdef UDC_LOAD_EN
        ld_b = 1'b1; ldv_b = 8'd30;
        cycle(1'b0, 3);
        chk("ld_clamp_hi", int'(data_b), 20);
        ldv_b = 8'd5;
        cycle(1'b0, 3);
        chk("ld_clamp_lo", int'(data_b), 10);
        ldv_b = 8'd15;
        cycle(1'b1, 0);
        chk("ld_priority", int'(data_b), 15);
        chk("ld_tc",       int'(tc_b),   0);
        ld_b = 1'b0;
        ld_a = 1'b1; ldv_a = 8'd200;
        cycle(1'b1, 1);
        chk("ld_a_data", int'(data_a), 200);
        ld_a = 1'b0;
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) == 0) do_reset();
`ifdef UDC_LOAD_EN
            ld_a  = ($urandom_range(7) == 0);
            ld_b  = ($urandom_range(7) == 0);
            ldv_a = 8'($urandom_range(255));
            ldv_b = 8'($urandom_range(31));
`endif
            cycle($urandom_range(7) != 0, int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
